mult_seq_ctrl: RTL
==================

Name: mult_seq_ctrl

Overview:
- Sequential add-shift multiplier: controller plus accumulator/multiplier datapath, one partial-product step per clock, iteration counter CT.
- Sits beside the combinational next-state slices of the multiplier cell and owns sequencing: START/READY handshake, operand capture, iteration count, product hand-off.
- Unsigned WIDTH x WIDTH -> 2*WIDTH product.

Parameters:
- WIDTH, 4, operand width in bits; minimum 2.
- CTW, $clog2(WIDTH), width of iteration counter CT; derived, must not be overridden.

Ports:
- CK  input  1  clock, rising edge.
- RSTN  input  1  asynchronous active-low reset.
- START  input  1  start request; sampled only in IDLE.
- AX  input  WIDTH  multiplicand; captured on accepted START.
- MR  input  WIDTH  multiplier; captured on accepted START.
- READY  output  1  high in IDLE only.
- BUSY  output  1  high in RUN only.
- DONE  output  1  one-cycle pulse; P valid from this cycle on.
- P  output  2*WIDTH  product; holds until next DONE.
- CT  output  CTW  iteration counter, 0..WIDTH-1.

Behaviour:
- One clock (CK) for everything; reset is asynchronous, active-low on RSTN. Assertion takes effect immediately, independent of CK.
- Reset values: state=IDLE, READY=1, BUSY=0, DONE=0, P=0, CT=0; internal AXR, A (accumulator high half), Q (multiplier/low half) = 0.
- States: IDLE, RUN, DONE. READY, BUSY and DONE are Moore outputs decoded from state.
- IDLE: on a CK edge with START=1: AXR<=AX, Q<=MR, A<=0, CT<=0, go to RUN. START=0 keeps IDLE.
- RUN, each edge:
  - {c,s} = A + (Q[0] ? AXR : 0), computed in WIDTH+1 bits.
  - {A,Q} <= {c, s, Q[WIDTH-1:1]}, i.e. 2*WIDTH+1 bits shifted right by one.
  - If CT==WIDTH-1: go to DONE and load P<={c,s,Q[WIDTH-1:1]} on this same edge. Otherwise CT<=CT+1.
- DONE: DONE=1 for exactly one cycle, then go to IDLE. CT<=0 on the DONE->IDLE edge.
- Latency: START is accepted at edge k. RUN covers cycles k..k+WIDTH-1. DONE is high in the cycle after edge k+WIDTH. READY is low for WIDTH+1 cycles.
- START in RUN or DONE is ignored, with no queuing. START held high continuously starts a new operation on the first IDLE cycle, i.e. one cycle after DONE.
- AX/MR changes after acceptance do not affect the running operation.
- P changes only on the RUN->DONE edge, or to 0 on reset.
- Carry: the adder carry is never lost. AX=MR=2^WIDTH-1 gives (2^WIDTH-1)^2.
- Reset mid-operation aborts immediately: all state returns to reset values, including P=0. No DONE pulse is produced.

Optional Feature:
- Macro MULT_ZERO_SKIP_EN.
- Defined: in IDLE, START=1 with AX==0 or MR==0 skips RUN.
  - Go directly to DONE with P<=0 and CT left at 0.
  - DONE is high in the cycle after the accept edge; latency 1.
- Undefined: zero operands take the normal WIDTH-cycle RUN path and still produce P=0.

Test Plan:
- Reset: RSTN=0 mid-clock -> READY=1, BUSY=0, DONE=0, P=0, CT=0 without waiting for a CK edge.
- WIDTH=4, AX=13, MR=11, 1-cycle START pulse -> BUSY high 4 cycles with CT 0,1,2,3; DONE pulse in 5th cycle after accept; P=143 and held.
- AX=15, MR=15 -> P=225 (carry path). Then AX=1, MR=1 -> P=1. P stays 225 until the second DONE.
- START held high, AX=3, MR=5, AX changed to 9 during RUN -> P=15; next accept one cycle after DONE, using AX=9, MR=5 -> P=45; mid-RUN START ignored.
- Start AX=7, MR=9; pull RSTN low in RUN with CT=2 -> immediate IDLE, P=0, no DONE. Release, AX=7, MR=9 -> P=63.
- AX=0, MR=9 -> with MULT_ZERO_SKIP_EN: DONE 1 cycle after accept, BUSY never high, P=0. Without: DONE after 5 cycles, P=0.

Source files
------------

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: sequential unsigned add-shift multiplier (WIDTH x WIDTH -> 2*WIDTH).
// Each clock in RUN performs one partial-product step. The counter CT tracks the iterations.
//
// Ports:
//   CK     in   clock, rising edge
//   RSTN   in   asynchronous active-low reset
//   START  in   start request, sampled only in IDLE
//   AX     in   multiplicand, captured on an accepted START
//   MR     in   multiplier, captured on an accepted START
//   READY  out  high in IDLE only
//   BUSY   out  high in RUN only
//   DONE   out  one-cycle pulse; P is valid from this cycle on
//   P      out  product, held until the next DONE
//   CT     out  iteration counter, 0..WIDTH-1
//
// Optional feature macro: MULT_ZERO_SKIP_EN. When it is defined, a zero operand skips RUN
// and goes straight to DONE with P=0.

module mult_seq_ctrl #(
  parameter int unsigned WIDTH = 4,
  localparam int unsigned CTW  = $clog2(WIDTH)
) (
  input  logic               CK,
  input  logic               RSTN,
  input  logic               START,
  input  logic [WIDTH-1:0]   AX,
  input  logic [WIDTH-1:0]   MR,
  output logic               READY,
  output logic               BUSY,
  output logic               DONE,
  output logic [2*WIDTH-1:0] P,
  output logic [CTW-1:0]     CT
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               state_q;
  logic [WIDTH-1:0]     axr_q;   // captured multiplicand
  logic [WIDTH-1:0]     acc_q;   // accumulator (high half)
  logic [WIDTH-1:0]     mq_q;    // multiplier / low half of the product
  logic [CTW-1:0]       ct_q;
  logic [2*WIDTH-1:0]   p_q;
  logic                 ready_q;
  logic                 busy_q;
  logic                 done_q;

  // The partial sum is one bit wider than the operands, so the adder carry is kept.
  logic [WIDTH:0] sum;
  assign sum = {1'b0, acc_q} + (mq_q[0] ? {1'b0, axr_q} : '0);

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= StIdle;
      axr_q   <= '0;
      acc_q   <= '0;
      mq_q    <= '0;
      ct_q    <= '0;
      p_q     <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (START) begin
            axr_q <= AX;
            mq_q  <= MR;
            acc_q <= '0;
            ct_q  <= '0;
`ifdef MULT_ZERO_SKIP_EN
            if (AX == '0 || MR == '0) begin
              state_q <= StDone;
              p_q     <= '0;
              ready_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= StRun;
              ready_q <= 1'b0;
              busy_q  <= 1'b1;
            end
`else
            state_q <= StRun;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
`endif
          end
        end
        StRun: begin
          // {A,Q} <= {c,s,Q[WIDTH-1:1]}, so 2*WIDTH+1 bits are shifted right by one.
          acc_q <= sum[WIDTH:1];
          mq_q  <= {sum[0], mq_q[WIDTH-1:1]};
          if (ct_q == CTW'(WIDTH - 1)) begin
            state_q <= StDone;
            p_q     <= {sum, mq_q[WIDTH-1:1]};
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            ct_q <= ct_q + CTW'(1);
          end
        end
        StDone: begin
          state_q <= StIdle;
          ct_q    <= '0;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign READY = ready_q;
  assign BUSY  = busy_q;
  assign DONE  = done_q;
  assign P     = p_q;
  assign CT    = ct_q;

endmodule
